// File: rtl/fadd_tree_arb.sv
// -----------------------------------------------------------------------------
// fadd_tree_arb
//
// Round-robin arbiter that shares one fadd_tree reduction unit between NUM_REQ
// requesters. Each accepted handshake sends one K-element vector to the tree and
// pushes the requester's {src, warpid, reg_idxw} into an in-order tag FIFO. The
// tree's control outputs do not travel with the data, so the FIFO is what
// identifies the owner of each result. When a result leaves the tree, the block
// steers it to the requester at the FIFO head. Both directions are purely
// combinational, so the block adds no latency.
//
// Ports
//   clk, rst_n        clock and synchronous active-low reset
//   req_valid_i       per-requester valid
//   req_ready_o       per-requester ready (one-hot on issue, otherwise zero)
//   req_data_i        NUM_REQ packed vectors; requester r occupies slice r
//   req_warpid_i      per-requester warp tag
//   req_reg_idxw_i    per-requester destination register tag
//   tree_data_o       vector to the tree (zero when there is no grant)
//   tree_in_valid_o   tree input handshake, valid
//   tree_in_ready_i   tree input handshake, ready
//   tree_out_valid_i  tree output handshake, valid
//   tree_out_ready_o  tree output handshake, ready
//   tree_result_i     tree result
//   tree_fflags_i     tree exception flags
//   rsp_valid_o       one-hot response valid, indexed by the owning requester
//   rsp_ready_i       per-requester response ready
//   rsp_result_o      result passed through from the tree
//   rsp_fflags_o      flags passed through from the tree
//   rsp_warpid_o      warp tag of the head operation
//   rsp_reg_idxw_o    register tag of the head operation
//   rsp_src_o         index of the requester that owns the response
//   outstanding_o     number of operations in flight (FIFO occupancy)
//   err_o             sticky error: the tree produced a result with nothing in flight
// -----------------------------------------------------------------------------
module fadd_tree_arb #(
    parameter int NUM_REQ       = 4,
    parameter int SHAPE_K       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int DEPTH_WARP    = 4,
    parameter int MAX_OUT       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,

    input  logic [NUM_REQ-1:0]                         req_valid_i,
    output logic [NUM_REQ-1:0]                         req_ready_o,
    input  logic [NUM_REQ*SHAPE_K*ELEMENT_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ*DEPTH_WARP-1:0]              req_warpid_i,
    input  logic [NUM_REQ*8-1:0]                       req_reg_idxw_i,

    output logic [SHAPE_K*ELEMENT_WIDTH-1:0]           tree_data_o,
    output logic                                       tree_in_valid_o,
    input  logic                                       tree_in_ready_i,
    input  logic                                       tree_out_valid_i,
    output logic                                       tree_out_ready_o,
    input  logic [ELEMENT_WIDTH-1:0]                   tree_result_i,
    input  logic [4:0]                                 tree_fflags_i,

    output logic [NUM_REQ-1:0]                         rsp_valid_o,
    input  logic [NUM_REQ-1:0]                         rsp_ready_i,
    output logic [ELEMENT_WIDTH-1:0]                   rsp_result_o,
    output logic [4:0]                                 rsp_fflags_o,
    output logic [DEPTH_WARP-1:0]                      rsp_warpid_o,
    output logic [7:0]                                 rsp_reg_idxw_o,
    output logic [$clog2(NUM_REQ)-1:0]                 rsp_src_o,
    output logic [$clog2(MAX_OUT):0]                   outstanding_o,
    output logic                                       err_o
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int VW = SHAPE_K * ELEMENT_WIDTH;

    typedef struct packed {
        logic [SW-1:0]         src;
        logic [DEPTH_WARP-1:0] warpid;
        logic [7:0]            reg_idxw;
    } tag_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0] rr_q,       rr_d;
    logic          lock_v_q,   lock_v_d;
    logic [SW-1:0] lock_idx_q, lock_idx_d;
    logic [PW:0]   wptr_q,     wptr_d;      // extra MSB is the wrap bit
    logic [PW:0]   rptr_q,     rptr_d;
    logic          err_q,      err_d;
    tag_t          tag_mem_q [MAX_OUT];
    tag_t          tag_mem_d [MAX_OUT];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic          gnt_v;
    logic [SW-1:0] gnt_idx;

    // While locked the grant is frozen on lock_idx so the tree sees stable
    // valid/data. If that requester drops valid there is no grant this cycle;
    // the lock is cleared and arbitration restarts next cycle.
    always_comb begin : p_arb
        int cand;
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path through the block can infer a latch.
        cand    = 0;
        gnt_v   = 1'b0;
        gnt_idx = '0;
        if (lock_v_q) begin
            gnt_idx = lock_idx_q;
            gnt_v   = req_valid_i[lock_idx_q];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = (int'(rr_q) + i) % NUM_REQ;
                if (!gnt_v && req_valid_i[SW'(cand)]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = SW'(cand);
                end
            end
        end
    end

    // Pick the granted requester's slice with a compare per requester, so
    // every part-select has a constant base.
    logic [VW-1:0]         sel_data;
    logic [DEPTH_WARP-1:0] sel_warpid;
    logic [7:0]            sel_reg_idxw;

    always_comb begin : p_sel
        sel_data     = '0;
        sel_warpid   = '0;
        sel_reg_idxw = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt_idx == SW'(r)) begin
                sel_data     = req_data_i[r*VW +: VW];
                sel_warpid   = req_warpid_i[r*DEPTH_WARP +: DEPTH_WARP];
                sel_reg_idxw = req_reg_idxw_i[r*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO status
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    tag_t head;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &&
                        (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign head       = tag_mem_q[rptr_q[PW-1:0]];

    // ------------------------------------------------------------------
    // Tree input side
    // ------------------------------------------------------------------
    logic issue;
    logic stall;

    // Full is taken from the registered pointers, so a pop in the same cycle
    // does not let an issue through; issue resumes on the following cycle.
    // Every output is qualified by rst_n so it reads zero throughout reset.
    assign tree_in_valid_o = rst_n & gnt_v & ~fifo_full;
    assign issue           = tree_in_valid_o &  tree_in_ready_i;
    assign stall           = tree_in_valid_o & ~tree_in_ready_i;
    assign tree_data_o     = (rst_n && gnt_v) ? sel_data : '0;

    always_comb begin : p_req_ready
        req_ready_o = '0;
        if (issue) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tree output / response side
    // ------------------------------------------------------------------
    logic pop;
    logic head_v;

    assign head_v           = rst_n & ~fifo_empty;
    // With an empty FIFO there is no owner, so a spurious result is never
    // accepted; it only raises err.
    assign tree_out_ready_o = head_v & rsp_ready_i[head.src];
    assign pop              = tree_out_valid_i & tree_out_ready_o;

    always_comb begin : p_rsp_valid
        rsp_valid_o = '0;
        if (head_v && tree_out_valid_i) begin
            rsp_valid_o[head.src] = 1'b1;
        end
    end

    assign rsp_result_o   = rst_n  ? tree_result_i : '0;
    assign rsp_fflags_o   = rst_n  ? tree_fflags_i : '0;
    assign rsp_warpid_o   = head_v ? head.warpid   : '0;
    assign rsp_reg_idxw_o = head_v ? head.reg_idxw : '0;
    assign rsp_src_o      = head_v ? head.src      : '0;

    assign outstanding_o  = rst_n ? (wptr_q - rptr_q) : '0;
    assign err_o          = rst_n & err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next
        rr_d       = rr_q;
        lock_v_d   = lock_v_q;
        lock_idx_d = lock_idx_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_d      = err_q;
        tag_mem_d  = tag_mem_q;

        // The locked requester withdrew its request: drop the lock so the
        // arbiter cannot deadlock on it.
        if (lock_v_q && !req_valid_i[lock_idx_q]) begin
            lock_v_d = 1'b0;
        end

        if (issue) begin
            tag_mem_d[wptr_q[PW-1:0]] = '{src: gnt_idx, warpid: sel_warpid,
                                          reg_idxw: sel_reg_idxw};
            wptr_d   = wptr_q + 1'b1;
            rr_d     = (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            lock_v_d = 1'b0;
        end else if (stall) begin
            lock_v_d   = 1'b1;
            lock_idx_d = gnt_idx;
        end

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        if (tree_out_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples its _d value from before the clock edge.
        if (!rst_n) begin
            rr_q       <= '0;
            lock_v_q   <= 1'b0;
            lock_idx_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_v_q   <= lock_v_d;
            lock_idx_q <= lock_idx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the tag storage has no reset. Resetting the pointers already marks
    // every entry invalid, and an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end

endmodule

// File: tb/tb_fadd_tree_arb.sv
// -----------------------------------------------------------------------------
// tb_fadd_tree_arb
//
// Self-checking bench for fadd_tree_arb. The bench itself plays the fadd_tree:
// each accepted vector is reduced to a sum, and results come back in issue
// order from a queue. The reference model keeps in-flight operations in a
// queue and applies the round-robin and stall rules with plain integers.
// -----------------------------------------------------------------------------
module tb_fadd_tree_arb;

    localparam int NUM_REQ       = 4;
    localparam int SHAPE_K       = 8;
    localparam int ELEMENT_WIDTH = 9;
    localparam int DEPTH_WARP    = 4;
    localparam int MAX_OUT       = 4;
    localparam int SW            = $clog2(NUM_REQ);
    localparam int VW            = SHAPE_K * ELEMENT_WIDTH;
    localparam int OW            = $clog2(MAX_OUT) + 1;

    logic                            clk;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              req_valid_i;
    logic [NUM_REQ-1:0]              req_ready_o;
    logic [NUM_REQ*VW-1:0]           req_data_i;
    logic [NUM_REQ*DEPTH_WARP-1:0]   req_warpid_i;
    logic [NUM_REQ*8-1:0]            req_reg_idxw_i;
    logic [VW-1:0]                   tree_data_o;
    logic                            tree_in_valid_o;
    logic                            tree_in_ready_i;
    logic                            tree_out_valid_i;
    logic                            tree_out_ready_o;
    logic [ELEMENT_WIDTH-1:0]        tree_result_i;
    logic [4:0]                      tree_fflags_i;
    logic [NUM_REQ-1:0]              rsp_valid_o;
    logic [NUM_REQ-1:0]              rsp_ready_i;
    logic [ELEMENT_WIDTH-1:0]        rsp_result_o;
    logic [4:0]                      rsp_fflags_o;
    logic [DEPTH_WARP-1:0]           rsp_warpid_o;
    logic [7:0]                      rsp_reg_idxw_o;
    logic [SW-1:0]                   rsp_src_o;
    logic [OW-1:0]                   outstanding_o;
    logic                            err_o;

    fadd_tree_arb #(
        .NUM_REQ       (NUM_REQ),
        .SHAPE_K       (SHAPE_K),
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .DEPTH_WARP    (DEPTH_WARP),
        .MAX_OUT       (MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .req_warpid_i     (req_warpid_i),
        .req_reg_idxw_i   (req_reg_idxw_i),
        .tree_data_o      (tree_data_o),
        .tree_in_valid_o  (tree_in_valid_o),
        .tree_in_ready_i  (tree_in_ready_i),
        .tree_out_valid_i (tree_out_valid_i),
        .tree_out_ready_o (tree_out_ready_o),
        .tree_result_i    (tree_result_i),
        .tree_fflags_i    (tree_fflags_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_result_o     (rsp_result_o),
        .rsp_fflags_o     (rsp_fflags_o),
        .rsp_warpid_o     (rsp_warpid_o),
        .rsp_reg_idxw_o   (rsp_reg_idxw_o),
        .rsp_src_o        (rsp_src_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int                       src;
        logic [DEPTH_WARP-1:0]    warpid;
        logic [7:0]               reg_idxw;
        logic [ELEMENT_WIDTH-1:0] result;
        logic [4:0]               fflags;
    } op_t;

    op_t                   inflight[$];      // issued, not yet returned
    logic [VW-1:0]         vec [NUM_REQ];    // pending vector per requester
    logic [DEPTH_WARP-1:0] wid [NUM_REQ];
    logic [7:0]            rid [NUM_REQ];
    int                    rr_m;             // next requester to search from
    bit                    pend_v;           // presented but not yet accepted
    int                    pend_idx;
    bit                    err_m;

    int n_pass;
    int n_fail;
    int n_total;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ELEMENT_WIDTH-1:0] vec_sum(input logic [VW-1:0] v);
        logic [ELEMENT_WIDTH-1:0] s;
        s = '0;
        for (int k = 0; k < SHAPE_K; k++) s += v[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        return s;
    endfunction

    task automatic new_req(input int r);
        for (int k = 0; k < SHAPE_K; k++) vec[r][k*ELEMENT_WIDTH +: ELEMENT_WIDTH] = ELEMENT_WIDTH'($urandom);
        wid[r] = DEPTH_WARP'($urandom);
        rid[r] = 8'($urandom);
    endtask

    task automatic model_reset();
        inflight.delete();
        rr_m   = 0;
        pend_v = 1'b0;
        pend_idx = 0;
        err_m  = 1'b0;
    endtask

    // Hold reset for n cycles with every input active; all outputs must read 0.
    task automatic reset_cycles(input int n);
        rst_n            = 1'b0;
        req_valid_i      = '1;
        tree_in_ready_i  = 1'b1;
        tree_out_valid_i = 1'b1;
        rsp_ready_i      = '1;
        tree_result_i    = ELEMENT_WIDTH'($urandom);
        tree_fflags_i    = 5'($urandom);
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data_i[r*VW +: VW]                 = vec[r];
            req_warpid_i[r*DEPTH_WARP +: DEPTH_WARP] = wid[r];
            req_reg_idxw_i[r*8 +: 8]               = rid[r];
        end
        for (int c = 0; c < n; c++) begin
            #2;
            check("rst_req_ready",   req_ready_o,      0);
            check("rst_tree_valid",  tree_in_valid_o,  0);
            check("rst_tree_data",   tree_data_o,      0);
            check("rst_out_ready",   tree_out_ready_o, 0);
            check("rst_rsp_valid",   rsp_valid_o,      0);
            check("rst_rsp_src",     rsp_src_o,        0);
            check("rst_rsp_warpid",  rsp_warpid_o,     0);
            check("rst_rsp_reg",     rsp_reg_idxw_o,   0);
            check("rst_outstanding", outstanding_o,    0);
            check("rst_err",         err_o,            0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // clock, then advance the model. got_rdy returns the observed req_ready_o.
    task automatic cycle(input logic [NUM_REQ-1:0] valid, input bit in_rdy,
                         input logic [NUM_REQ-1:0] rrdy, input bit out_en,
                         input bit spur, output logic [NUM_REQ-1:0] got_rdy);
        int                 g;
        bit                 gv;
        bit                 full;
        bit                 exp_tiv;
        bit                 exp_issue;
        bit                 exp_pop;
        bit                 out_v;
        op_t                head;
        op_t                op;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_rsp;

        req_valid_i = valid;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data_i[r*VW +: VW]                   = vec[r];
            req_warpid_i[r*DEPTH_WARP +: DEPTH_WARP] = wid[r];
            req_reg_idxw_i[r*8 +: 8]                 = rid[r];
        end
        tree_in_ready_i  = in_rdy;
        rsp_ready_i      = rrdy;
        out_v            = spur || (out_en && inflight.size() > 0);
        tree_out_valid_i = out_v;
        if (inflight.size() > 0) begin
            tree_result_i = inflight[0].result;
            tree_fflags_i = inflight[0].fflags;
        end else begin
            tree_result_i = ELEMENT_WIDTH'($urandom);
            tree_fflags_i = 5'($urandom);
        end
        #2;

        // Expected grant: a stalled presentation holds, otherwise search from rr.
        full = (inflight.size() == MAX_OUT);
        gv   = 1'b0;
        g    = 0;
        if (pend_v) begin
            g  = pend_idx;
            gv = valid[pend_idx];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gv && valid[(rr_m + i) % NUM_REQ]) begin
                    gv = 1'b1;
                    g  = (rr_m + i) % NUM_REQ;
                end
            end
        end
        exp_tiv   = gv && !full;
        exp_issue = exp_tiv && in_rdy;
        exp_rdy   = exp_issue ? (NUM_REQ'(1) << g) : '0;

        got_rdy = req_ready_o;
        check("tree_in_valid", tree_in_valid_o, exp_tiv);
        check("req_ready",     req_ready_o,     exp_rdy);
        check("tree_data",     tree_data_o,     gv ? vec[g] : '0);
        check("outstanding",   outstanding_o,   inflight.size());
        check("err",           err_o,           err_m);

        if (inflight.size() > 0) begin
            head    = inflight[0];
            exp_rsp = out_v ? (NUM_REQ'(1) << head.src) : '0;
            exp_pop = out_v && rrdy[head.src];
            check("rsp_valid",      rsp_valid_o,      exp_rsp);
            check("tree_out_ready", tree_out_ready_o, rrdy[head.src]);
            check("rsp_src",        rsp_src_o,        head.src);
            check("rsp_warpid",     rsp_warpid_o,     head.warpid);
            check("rsp_reg_idxw",   rsp_reg_idxw_o,   head.reg_idxw);
            check("rsp_result",     rsp_result_o,     head.result);
            check("rsp_fflags",     rsp_fflags_o,     head.fflags);
        end else begin
            exp_pop = 1'b0;
            check("rsp_valid_empty",  rsp_valid_o,      0);
            check("out_ready_empty",  tree_out_ready_o, 0);
            if (out_v) err_m = 1'b1;
        end

        @(posedge clk);
        if (exp_pop) void'(inflight.pop_front());
        if (exp_issue) begin
            op.src      = g;
            op.warpid   = wid[g];
            op.reg_idxw = rid[g];
            op.result   = vec_sum(vec[g]);
            op.fflags   = 5'($urandom);
            inflight.push_back(op);
            new_req(g);
            pend_v = 1'b0;
            rr_m   = (g + 1) % NUM_REQ;
        end else if (exp_tiv) begin
            pend_v   = 1'b1;
            pend_idx = g;
        end else if (pend_v && !gv) begin
            pend_v = 1'b0;
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by a randomized phase
    // ------------------------------------------------------------------
    initial begin
        logic [NUM_REQ-1:0] g1h;
        logic [NUM_REQ-1:0] exp1h;
        logic [VW-1:0]      stall_vec;

        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        for (int r = 0; r < NUM_REQ; r++) new_req(r);

        // Reset held 3 cycles with everything requesting.
        reset_cycles(3);

        // Round-robin: first grant goes to 0, then rotates every cycle.
        for (int k = 0; k < 7; k++) begin
            cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
            exp1h = NUM_REQ'(1) << (k % NUM_REQ);
            check("rr_grant", g1h, exp1h);
        end
        repeat (2) cycle('0, 1'b1, '1, 1'b1, 1'b0, g1h);

        // Stall lock: search starts at 3, so requester 1 wins and must hold.
        stall_vec = vec[1];
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0110, 1'b0, '1, 1'b1, 1'b0, g1h);
            check("stall_no_ready", g1h, 0);
            check("stall_data_stable", tree_data_o, stall_vec);
        end
        cycle(4'b0110, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("stall_release_1", g1h, 4'b0010);
        cycle(4'b0110, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("stall_next_2", g1h, 4'b0100);
        repeat (2) cycle('0, 1'b1, '1, 1'b1, 1'b0, g1h);

        // Full: responses blocked, five attempts give four issues (3,0,1,2).
        for (int k = 0; k < 5; k++) begin
            cycle('1, 1'b1, '0, 1'b1, 1'b0, g1h);
            exp1h = (k < MAX_OUT) ? (NUM_REQ'(1) << ((3 + k) % NUM_REQ)) : '0;
            check("full_grant", g1h, exp1h);
        end
        check("full_occupancy", outstanding_o, MAX_OUT);
        cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("full_pop_no_issue", g1h, 0);
        cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("full_issue_resumes", g1h, 4'b1000);
        repeat (MAX_OUT + 1) cycle('0, 1'b1, '1, 1'b1, 1'b0, g1h);

        // Simultaneous push and pop at occupancy 2.
        repeat (2) cycle('1, 1'b1, '0, 1'b1, 1'b0, g1h);
        check("pushpop_pre", outstanding_o, 2);
        cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("pushpop_grant", g1h, 4'b0100);
        check("pushpop_occupancy", outstanding_o, 2);
        repeat (3) cycle('0, 1'b1, '1, 1'b1, 1'b0, g1h);

        // Randomized traffic: valids, tree readiness and response readiness.
        for (int k = 0; k < 80; k++) begin
            cycle(NUM_REQ'($urandom), $urandom_range(0, 3) != 0,
                  NUM_REQ'($urandom), $urandom_range(0, 1) == 1, 1'b0, g1h);
        end
        repeat (MAX_OUT + 2) cycle('0, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("drained", outstanding_o, 0);

        // Spurious tree output with nothing in flight.
        cycle('0, 1'b1, '1, 1'b0, 1'b1, g1h);
        check("err_set", err_o, 1);
        repeat (3) cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("err_sticky", err_o, 1);

        // Reset mid-operation clears err and discards in-flight tags.
        reset_cycles(2);
        cycle('1, 1'b1, '1, 1'b1, 1'b0, g1h);
        check("post_reset_grant0", g1h, 4'b0001);
        check("post_reset_err", err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fadd_tree_arb.md
# fadd_tree_arb

Round-robin arbiter that shares one `fadd_tree` reduction unit between `NUM_REQ` requesters, such as tensor-core lanes or warp slots. It issues one K-vector per accepted handshake and records the requester and destination tags in an in-order tag FIFO, because the tree's ctrl outputs are combinational pass-throughs and do not follow data down the pipeline. When a result leaves the tree, the block steers it back to the requester that issued it. It sits between the requester ports and the `fadd_tree` input/output handshakes.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2); the source index is `SW = $clog2(NUM_REQ)` bits wide.
- `SHAPE_K`, 8, elements per vector.
- `ELEMENT_WIDTH`, 9, element/result width.
- `DEPTH_WARP`, 4, warp-id width.
- `MAX_OUT`, 4, tag FIFO depth, which is also the maximum number of in-flight operations (power of 2, ≥2).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  per-requester valid.
- `req_ready_o`  out  NUM_REQ  per-requester ready (one-hot or zero).
- `req_data_i`  in  NUM_REQ*SHAPE_K*ELEMENT_WIDTH  vectors; requester r occupies slice r.
- `req_warpid_i`  in  NUM_REQ*DEPTH_WARP  warp tag per requester.
- `req_reg_idxw_i`  in  NUM_REQ*8  destination register tag per requester.
- `tree_data_o`  out  SHAPE_K*ELEMENT_WIDTH  vector to the tree.
- `tree_in_valid_o` / `tree_in_ready_i`  out/in  1  tree input handshake.
- `tree_out_valid_i` / `tree_out_ready_o`  in/out  1  tree output handshake.
- `tree_result_i`  in  ELEMENT_WIDTH  tree result.
- `tree_fflags_i`  in  5  tree flags.
- `rsp_valid_o`  out  NUM_REQ  one-hot response valid.
- `rsp_ready_i`  in  NUM_REQ  per-requester response ready.
- `rsp_result_o`  out  ELEMENT_WIDTH  result.
- `rsp_fflags_o`  out  5  flags.
- `rsp_warpid_o`  out  DEPTH_WARP  warp tag.
- `rsp_reg_idxw_o`  out  8  register tag.
- `rsp_src_o`  out  SW  index of the requester that owns the response.
- `outstanding_o`  out  $clog2(MAX_OUT)+1  current FIFO occupancy.
- `err_o`  out  1  sticky protocol error.

## Operation
- **State:** round-robin pointer `rr` (SW bits), lock register `lock_v` + `lock_idx`, tag FIFO of entries `{src, warpid, reg_idxw}`, and `err_o`.
- **Grant, unlocked:** grant the first requester with `req_valid_i` high, searching from `rr` upward and wrapping modulo NUM_REQ.
- **Grant, locked:** the grant is `lock_idx`.
- **Tree input drive:** `tree_in_valid_o` = (granted requester valid) & !fifo_full. `tree_data_o` is the granted requester's slice; it is 0 when there is no grant.
- **Issue:** occurs when `tree_in_valid_o & tree_in_ready_i`. On issue:
  - `req_ready_o[g]` = 1, same cycle (combinational).
  - Push `{g, warpid[g], reg_idxw[g]}` into the tag FIFO.
  - `rr` ← g+1, wrapping.
  - `lock_v` ← 0.
- **Stall:** when `tree_in_valid_o & !tree_in_ready_i`, set `lock_v` ← 1 and `lock_idx` ← g. The grant must not move while the tree has not accepted, so the tree sees stable valid/data.
- **Lock release:** if the locked requester drops valid, clear the lock and re-arbitrate next cycle. This is a requester protocol violation, but it must not deadlock the arbiter.
- **FIFO full:** no issue; all `req_ready_o` = 0. A pop in the same cycle does not enable an issue; issue resumes the following cycle.
- **Response drive:**
  - head = FIFO head entry.
  - `rsp_valid_o[head.src]` = `tree_out_valid_i` & !fifo_empty; all other bits are 0.
  - `tree_out_ready_o` = !fifo_empty & `rsp_ready_i[head.src]`.
  - Result and flags pass through combinationally; tags come from head.
- **Pop:** on `tree_out_valid_i & tree_out_ready_o`.
- **Simultaneous push and pop:** both occur, and occupancy is unchanged.
- **Error:** `tree_out_valid_i` while the FIFO is empty sets `err_o` ← 1. `err_o` stays set until reset, and `tree_out_ready_o` stays 0 in that case.
- **FIFO pointers:** log2(MAX_OUT) bits plus a wrap bit. Full = MAX_OUT entries.

## Timing
- **Zero added latency:** issue and response are purely combinational paths through the block. Result order equals issue order, because the tree is in-order.
- **Reset (synchronous):** while `rst_n` = 0, the following are all forced to 0 regardless of inputs:
  - `rr`, `lock_v`, `lock_idx`, FIFO pointers, `err_o`, `outstanding_o`;
  - `req_ready_o`, `tree_in_valid_o`, `tree_out_ready_o`, `rsp_valid_o`, `tree_data_o`, `rsp_*` tags.
- **Reset mid-operation:** in-flight tags are discarded. The environment must flush the tree concurrently.
- **Back-to-back issue:** one issue per cycle is sustained while the tree is ready and the FIFO is not full.
- **Fairness:** with every requester valid, the tree is always ready and responses are always drained, so the occupancy never reaches MAX_OUT. The grants then rotate 0,1,2,…,NUM_REQ-1,0 with one issue per cycle.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with all `req_valid_i` = 1 → all outputs 0. After release, the first grant goes to requester 0.
- **Round-robin:** all 4 requesters valid, tree ready, responses drained every cycle → grants 0,1,2,3,0,1 on consecutive cycles; each requester receives its result with a matching `rsp_src_o`, `warpid` and `reg_idxw`.
- **Stall lock:** requesters 1 and 2 valid, `tree_in_ready_i` = 0 for 3 cycles → `tree_data_o` stays requester 1's vector and `req_ready_o` stays 0. On ready, 1 issues; 2 issues on the next cycle.
- **Full:** `rsp_ready_i` = 0 with 5 issue attempts → 4 issues, `outstanding_o` = 4, then `req_ready_o` = 0. Raise `rsp_ready_i` → one pop; issue resumes one cycle later.
- **Simultaneous push and pop:** occupancy 2, issue and pop in the same cycle → `outstanding_o` remains 2, and the FIFO order is preserved.
- **Spurious output:** FIFO empty, `tree_out_valid_i` pulsed → `err_o` = 1 and stays 1, `rsp_valid_o` = 0; it clears only on reset.
